heat_seq: RTL and testbench

HEAT_SEQ -- requirements
Module: heat_seq

---
 rtl/bath_pkg.sv | 14 +
 rtl/heat_timer.sv | 21 ++
 rtl/heat_seq.sv | 73 +++++++
 tb/tb_heat_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bath_pkg.sv
// bath_pkg: state encoding and default tick constants for the bathroom heater sequencer
package bath_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREFAN = 3'd1,
    S_HEAT   = 3'd2,
    S_COOL   = 3'd3,
    S_VENT   = 3'd4
  } state_t;
  localparam int PREFAN_TICKS_DEF   = 4;
  localparam int COOL_TICKS_DEF     = 20;
  localparam int AUTO_OFF_TICKS_DEF = 3600;
  localparam int CNT_W_DEF          = 12;
endpackage

// File: rtl/heat_timer.sv
// heat_timer: loadable tick down-counter; expire marks the tick that takes it from 1 to 0
module heat_timer
  import bath_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk1M,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expire
);
  assign expire = tick && count == W'(1);
  // load wins over counting; the count parks at zero in untimed states
  always_ff @(posedge clk1M or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= value;
    else if (tick && count != '0) count <= count - 1'b1;
endmodule

// File: rtl/heat_seq.sv
// heat_seq: heater/fan sequencer with fan pre-run and run-on; HEAT_AUTO_OFF_EN enables the heating time limit
module heat_seq
  import bath_pkg::*;
#(
  parameter int PREFAN_TICKS   = PREFAN_TICKS_DEF,
  parameter int COOL_TICKS     = COOL_TICKS_DEF,
  parameter int AUTO_OFF_TICKS = AUTO_OFF_TICKS_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clk1M,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             power_on,
  input  logic             mode_heat,
  input  logic             mode_vent,
  input  logic             over_temp,
  output logic             heater_en,
  output logic             fan_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] remain,
  output logic             busy
);
`ifdef HEAT_AUTO_OFF_EN
  localparam bit AUTO_OFF = 1'b1;
`else
  localparam bit AUTO_OFF = 1'b0;
`endif
  localparam logic [CNT_W-1:0] HEAT_LOAD = AUTO_OFF ? CNT_W'(AUTO_OFF_TICKS) : '0;
  state_t st, nxt, idle_nxt;
  logic heat_req, load, expire;
  logic [CNT_W-1:0] load_val;
  // next state; the heat request covers every non-timer exit from PREFAN and HEAT, so it beats a coincident tick
  always_comb begin
    heat_req = power_on & mode_heat & ~over_temp;
    idle_nxt = heat_req ? S_PREFAN : (power_on & mode_vent) ? S_VENT : S_IDLE;
    nxt = S_IDLE;
    case (st)
      S_IDLE:   nxt = idle_nxt;
      S_PREFAN: nxt = !heat_req ? S_IDLE : expire ? S_HEAT : S_PREFAN;
      S_HEAT:   nxt = (!heat_req || (AUTO_OFF && expire)) ? S_COOL : S_HEAT;
      S_COOL:   nxt = expire ? idle_nxt : S_COOL;
      S_VENT:   nxt = heat_req ? S_PREFAN : (power_on & mode_vent) ? S_VENT : S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    load = nxt != st;
    load_val = nxt == S_PREFAN ? CNT_W'(PREFAN_TICKS) :
               nxt == S_COOL   ? CNT_W'(COOL_TICKS)   :
               nxt == S_HEAT   ? HEAT_LOAD            : '0;
  end
  // drives are decoded from the next state so they change on the same edge as the state register
  always_ff @(posedge clk1M or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      heater_en <= 1'b0;
      fan_en <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= nxt;
      heater_en <= nxt == S_HEAT;
      fan_en <= nxt != S_IDLE;
      busy <= nxt == S_COOL;
    end
  assign state = st;
  heat_timer #(.W(CNT_W)) u_timer (
    .clk1M (clk1M),
    .rst_n (rst_n),
    .load  (load),
    .value (load_val),
    .tick  (tick),
    .count (remain),
    .expire(expire)
  );
endmodule

// File: tb/tb_heat_seq.sv
// tb_heat_seq: directed scenarios plus randomized traffic against a tick-counting reference model
module tb_heat_seq;
  localparam int P = 4, C = 20, A = 8, W = 12;
`ifdef HEAT_AUTO_OFF_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk1M = 0, rst_n = 0, tick = 0;
  logic power_on = 0, mode_heat = 0, mode_vent = 0, over_temp = 0;
  logic heater_en, fan_en, busy;
  logic [2:0] state;
  logic [W-1:0] remain;
  int tests = 0, fails = 0;
  int m_state = 0, m_ticks = 0;
  bit sb_en = 0;
  logic [2:0] es;
  logic [W-1:0] er;
  logic eh, ef, eb;

  heat_seq #(.PREFAN_TICKS(P), .COOL_TICKS(C), .AUTO_OFF_TICKS(A), .CNT_W(W)) dut (
    .clk1M(clk1M), .rst_n(rst_n), .tick(tick), .power_on(power_on), .mode_heat(mode_heat),
    .mode_vent(mode_vent), .over_temp(over_temp), .heater_en(heater_en), .fan_en(fan_en),
    .state(state), .remain(remain), .busy(busy)
  );

  always #5 clk1M = ~clk1M;

  // reference: track ticks seen since entering the current state and compare to each state's limit
  function automatic int m_remain();
    case (m_state)
      1: return P - m_ticks;
      2: return AUTO ? A - m_ticks : 0;
      3: return C - m_ticks;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_ticks = 0;
  endfunction

  function automatic void model_step(input bit t);
    bit hr;
    int idle_n, n;
    hr = power_on && mode_heat && !over_temp;
    idle_n = hr ? 1 : (power_on && mode_vent) ? 4 : 0;
    n = m_state;
    case (m_state)
      0: n = idle_n;
      1: n = !hr ? 0 : (t && m_ticks + 1 == P) ? 2 : 1;
      2: n = (!hr || (AUTO && t && m_ticks + 1 == A)) ? 3 : 2;
      3: n = (t && m_ticks + 1 == C) ? idle_n : 3;
      4: n = hr ? 1 : (!power_on || !mode_vent) ? 0 : 4;
      default: n = 0;
    endcase
    if (n != m_state) begin
      m_state = n;
      m_ticks = 0;
    end else if (t) m_ticks++;
  endfunction

  task automatic cyc(input bit t);
    tick = t;
    @(posedge clk1M);
    model_step(t);
    #1 tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cyc(0);
      cyc(1);
    end
  endtask

  // scoreboard and heater invariant, sampled on the falling edge
  always @(negedge clk1M) if (sb_en) begin
    es = 3'(m_state);
    er = W'(m_remain());
    eh = m_state == 2;
    ef = m_state != 0;
    eb = m_state == 3;
    tests++;
    if ({heater_en, fan_en, busy, state, remain} !== {eh, ef, eb, es, er}) begin
      fails++;
      if (fails < 20)
        $display("FAIL scoreboard t=%0t got h=%b f=%b b=%b st=%0d rem=%0d want h=%b f=%b b=%b st=%0d rem=%0d",
                 $time, heater_en, fan_en, busy, state, remain, eh, ef, eb, es, er);
    end
    tests++;
    if (heater_en === 1'b1 && (fan_en !== 1'b1 || state !== 3'd2)) begin
      fails++;
      $display("FAIL invariant t=%0t heater=1 fan=%b state=%0d want fan=1 state=2", $time, fan_en, state);
    end
  end

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    #1;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if (heater_en !== 1'b0) begin fails++; $display("FAIL reset_heater got %b want 0", heater_en); end
    tests++; if (fan_en !== 1'b0) begin fails++; $display("FAIL reset_fan got %b want 0", fan_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (remain !== '0) begin fails++; $display("FAIL reset_remain got %0d want 0", remain); end
    @(negedge clk1M);
    rst_n = 1;
    sb_en = 1;
  endtask

  task automatic test_heat_start();
    power_on = 1;
    mode_heat = 1;
    cyc(0);
    tests++; if ({state, fan_en, heater_en} !== {3'd1, 1'b1, 1'b0}) begin fails++; $display("FAIL start_prefan got st=%0d f=%b h=%b want st=1 f=1 h=0", state, fan_en, heater_en); end
    tests++; if (remain !== W'(P)) begin fails++; $display("FAIL start_remain got %0d want %0d", remain, P); end
    for (int i = 1; i <= P; i++) begin
      repeat ($urandom_range(1, 3)) cyc(0);
      cyc(1);
      if (i < P) begin
        tests++; if (heater_en !== 1'b0) begin fails++; $display("FAIL start_early tick %0d got h=%b want 0", i, heater_en); end
      end else begin
        tests++; if ({state, heater_en} !== {3'd2, 1'b1}) begin fails++; $display("FAIL start_heat got st=%0d h=%b want st=2 h=1", state, heater_en); end
      end
    end
  endtask

  task automatic test_heat_stop();
    mode_heat = 0;
    cyc(0);
    tests++; if ({state, heater_en, fan_en, busy} !== {3'd3, 1'b0, 1'b1, 1'b1}) begin fails++; $display("FAIL stop_cool got st=%0d h=%b f=%b b=%b want st=3 h=0 f=1 b=1", state, heater_en, fan_en, busy); end
    for (int i = 1; i <= C; i++) begin
      ticks(1);
      if (i < C) begin
        tests++; if ({fan_en, busy} !== 2'b11) begin fails++; $display("FAIL stop_runon tick %0d got f=%b b=%b want 1 1", i, fan_en, busy); end
      end else begin
        tests++; if ({state, fan_en, busy} !== {3'd0, 1'b0, 1'b0}) begin fails++; $display("FAIL stop_idle got st=%0d f=%b b=%b want 0 0 0", state, fan_en, busy); end
      end
    end
  endtask

  task automatic test_over_temp();
    mode_heat = 1;
    cyc(0);
    ticks(1);
    over_temp = 1;
    cyc(1);
    tests++; if ({state, fan_en, heater_en} !== {3'd0, 1'b0, 1'b0}) begin fails++; $display("FAIL ot_prefan got st=%0d f=%b h=%b want 0 0 0", state, fan_en, heater_en); end
    over_temp = 0;
    cyc(0);
    ticks(P);
    over_temp = 1;
    cyc(0);
    tests++; if ({state, heater_en} !== {3'd3, 1'b0}) begin fails++; $display("FAIL ot_heat got st=%0d h=%b want st=3 h=0", state, heater_en); end
    over_temp = 0;
    mode_heat = 0;
    ticks(C);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL ot_cooldone got %0d want 0", state); end
  endtask

  task automatic test_auto_off();
    mode_heat = 1;
    cyc(0);
    ticks(P);
`ifdef HEAT_AUTO_OFF_EN
    ticks(A - 1);
    tests++; if ({state, heater_en, remain} !== {3'd2, 1'b1, W'(1)}) begin fails++; $display("FAIL auto_last got st=%0d h=%b rem=%0d want 2 1 1", state, heater_en, remain); end
    ticks(1);
    tests++; if ({state, heater_en} !== {3'd3, 1'b0}) begin fails++; $display("FAIL auto_expire got st=%0d h=%b want 3 0", state, heater_en); end
`else
    ticks(110);
    tests++; if ({state, heater_en, remain} !== {3'd2, 1'b1, W'(0)}) begin fails++; $display("FAIL no_auto got st=%0d h=%b rem=%0d want 2 1 0", state, heater_en, remain); end
`endif
    mode_heat = 0;
    cyc(0);
    ticks(C);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL auto_cooldone got %0d want 0", state); end
  endtask

  task automatic test_cool_rerequest();
    mode_heat = 1;
    cyc(0);
    ticks(P);
    mode_heat = 0;
    cyc(0);
    ticks(4);
    mode_heat = 1;
    ticks(1);
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL rereq_ignored got %0d want 3", state); end
    power_on = 0;
    ticks(3);
    power_on = 1;
    ticks(C - 9);
    tests++; if ({state, busy, remain} !== {3'd3, 1'b1, W'(1)}) begin fails++; $display("FAIL rereq_last got st=%0d b=%b rem=%0d want 3 1 1", state, busy, remain); end
    ticks(1);
    tests++; if ({state, remain} !== {3'd1, W'(P)}) begin fails++; $display("FAIL rereq_prefan got st=%0d rem=%0d want 1 %0d", state, remain, P); end
    mode_heat = 0;
    cyc(0);
    tests++; if ({state, fan_en} !== {3'd0, 1'b0}) begin fails++; $display("FAIL rereq_abort got st=%0d f=%b want 0 0", state, fan_en); end
    mode_vent = 1;
    cyc(0);
    tests++; if ({state, fan_en, heater_en} !== {3'd4, 1'b1, 1'b0}) begin fails++; $display("FAIL vent got st=%0d f=%b h=%b want 4 1 0", state, fan_en, heater_en); end
    mode_vent = 0;
    cyc(0);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL vent_exit got %0d want 0", state); end
  endtask

  task automatic test_tick_collision();
    mode_heat = 1;
    cyc(0);
    ticks(P - 1);
    mode_heat = 0;
    cyc(1);
    tests++; if ({state, heater_en} !== {3'd0, 1'b0}) begin fails++; $display("FAIL collision got st=%0d h=%b want 0 0", state, heater_en); end
  endtask

  task automatic test_reset_mid_run();
    mode_heat = 1;
    cyc(0);
    ticks(P + 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    tests++; if ({state, heater_en, fan_en} !== {3'd0, 1'b0, 1'b0}) begin fails++; $display("FAIL rst_heat got st=%0d h=%b f=%b want 0 0 0", state, heater_en, fan_en); end
    mode_heat = 0;
    @(negedge clk1M) #1 rst_n = 1;
    mode_heat = 1;
    cyc(0);
    ticks(P);
    mode_heat = 0;
    cyc(0);
    ticks(3);
    #2 rst_n = 0;
    model_reset();
    #1;
    tests++; if ({state, busy, fan_en, remain} !== {3'd0, 1'b0, 1'b0, W'(0)}) begin fails++; $display("FAIL rst_cool got st=%0d b=%b f=%b rem=%0d want 0 0 0 0", state, busy, fan_en, remain); end
    @(negedge clk1M) #1 rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) power_on = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 15) == 0) mode_heat = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) mode_vent = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) over_temp = $urandom_range(0, 3) == 0;
      cyc($urandom_range(0, 2) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_heat_start();
    test_heat_stop();
    test_over_temp();
    test_auto_off();
    test_cool_rerequest();
    test_tick_collision();
    test_reset_mid_run();
    test_random();
    @(negedge clk1M);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
